// File: rtl/combo_tracker.sv
// -----------------------------------------------------------------------------
// combo_tracker
//
// Tracks the running combo, the best combo, and per-category hit tallies
// (perfect / good / miss) for a two-lane rhythm game. All counters are kept
// as 4-digit BCD so the 7-segment drivers can use them directly. Each
// judgement goes through two register stages: decode, then update.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active high
//   clr           synchronous clear, active high (priority over judge_valid)
//   judge_valid   one-cycle pulse qualifying result_up / result_down
//   result_up     upper-lane judgement (00 PERFECT, 01 GOOD, 10 MISS, 11 NO_NOTE)
//   result_down   lower-lane judgement, same encoding
//   combo_bcd     current combo
//   max_combo_bcd highest combo since reset/clear
//   perfect_bcd   PERFECT lane-result tally
//   good_bcd      GOOD lane-result tally
//   miss_bcd      MISS lane-result tally
//   full_combo    1 while no MISS has been seen since reset/clear
//   combo_break   one-cycle pulse when a MISS ends a nonzero combo
// -----------------------------------------------------------------------------
module combo_tracker #(
    parameter logic [15:0] SAT_BCD = 16'h9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        judge_valid,
    input  logic [1:0]  result_up,
    input  logic [1:0]  result_down,
    output logic [15:0] combo_bcd,
    output logic [15:0] max_combo_bcd,
    output logic [15:0] perfect_bcd,
    output logic [15:0] good_bcd,
    output logic [15:0] miss_bcd,
    output logic        full_combo,
    output logic        combo_break
);

    typedef enum logic [1:0] {
        RES_PERFECT = 2'b00,
        RES_GOOD    = 2'b01,
        RES_MISS    = 2'b10,
        RES_NO_NOTE = 2'b11
    } result_t;

    // Number of lanes (0..2) carrying the given judgement code.
    function automatic logic [1:0] count_code(input logic [1:0] a,
                                              input logic [1:0] b,
                                              input result_t    code);
        return {1'b0, a == code} + {1'b0, b == code};
    endfunction

    // Add 0..2 to a 4-digit BCD value with digit-wise carry. A carry out of
    // the top digit means the true result passed 9999, so hold at SAT_BCD.
    function automatic logic [15:0] bcd_add(input logic [15:0] value,
                                            input logic [1:0]  inc);
        logic [15:0] sum;
        logic [4:0]  digit;
        logic [4:0]  carry;
        carry = {3'b000, inc};
        for (int i = 0; i < 4; i++) begin
            digit = {1'b0, value[i*4 +: 4]} + carry;
            if (digit > 5'd9) begin
                digit = digit - 5'd10;
                carry = 5'd1;
            end else begin
                carry = 5'd0;
            end
            sum[i*4 +: 4] = digit[3:0];
        end
        return (carry != 5'd0) ? SAT_BCD : sum;
    endfunction

    // ---------------------------------------------------------------- decode
    logic [1:0] dec_perf;
    logic [1:0] dec_good;
    logic [1:0] dec_miss;

    always_comb begin
        // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
        dec_perf = count_code(result_up, result_down, RES_PERFECT);
        dec_good = count_code(result_up, result_down, RES_GOOD);
        dec_miss = count_code(result_up, result_down, RES_MISS);
    end

    // --------------------------------------------------------------- stage 1
    logic       s1_valid;
    logic [1:0] s1_hits;
    logic [1:0] s1_perf;
    logic [1:0] s1_good;
    logic [1:0] s1_miss;
    logic       s1_any_miss;

    // NOTE: reset is asynchronous, so rst sits in the sensitivity list and is tested first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_hits     <= 2'd0;
            s1_perf     <= 2'd0;
            s1_good     <= 2'd0;
            s1_miss     <= 2'd0;
            s1_any_miss <= 1'b0;
        end else if (clr) begin
            s1_valid    <= 1'b0;
            s1_hits     <= 2'd0;
            s1_perf     <= 2'd0;
            s1_good     <= 2'd0;
            s1_miss     <= 2'd0;
            s1_any_miss <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            s1_valid <= judge_valid;
            if (judge_valid) begin
                s1_hits     <= dec_perf + dec_good;
                s1_perf     <= dec_perf;
                s1_good     <= dec_good;
                s1_miss     <= dec_miss;
                s1_any_miss <= (dec_miss != 2'd0);
            end
        end
    end

    // --------------------------------------------------------------- stage 2
    logic [15:0] combo_next;
    logic [15:0] max_next;

    always_comb begin
        combo_next = s1_any_miss ? 16'h0000 : bcd_add(combo_bcd, s1_hits);
        // BCD digits are ordered, so a plain unsigned compare ranks values correctly.
        max_next   = (combo_next > max_combo_bcd) ? combo_next : max_combo_bcd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            combo_bcd     <= 16'h0000;
            max_combo_bcd <= 16'h0000;
            perfect_bcd   <= 16'h0000;
            good_bcd      <= 16'h0000;
            miss_bcd      <= 16'h0000;
            full_combo    <= 1'b1;
            combo_break   <= 1'b0;
        end else if (clr) begin
            // Clear also drops whatever event is sitting in stage 1.
            combo_bcd     <= 16'h0000;
            max_combo_bcd <= 16'h0000;
            perfect_bcd   <= 16'h0000;
            good_bcd      <= 16'h0000;
            miss_bcd      <= 16'h0000;
            full_combo    <= 1'b1;
            combo_break   <= 1'b0;
        end else begin
            combo_break <= 1'b0;
            if (s1_valid) begin
                combo_bcd     <= combo_next;
                max_combo_bcd <= max_next;
                perfect_bcd   <= bcd_add(perfect_bcd, s1_perf);
                good_bcd      <= bcd_add(good_bcd, s1_good);
                miss_bcd      <= bcd_add(miss_bcd, s1_miss);
                // Only a miss that ends a live combo counts as a break.
                combo_break   <= s1_any_miss && (combo_bcd != 16'h0000);
                if (s1_any_miss) begin
                    full_combo <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_combo_tracker.sv
// -----------------------------------------------------------------------------
// tb_combo_tracker
//
// Self-checking bench for combo_tracker. A behavioural model keeps the
// counters as plain integers with min() saturation and converts them to BCD
// only for comparison. Directed scenarios follow the feature list; a
// randomized run compares every output every cycle.
// -----------------------------------------------------------------------------
module tb_combo_tracker;

    localparam logic [1:0] P = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] M = 2'b10;
    localparam logic [1:0] N = 2'b11;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        judge_valid;
    logic [1:0]  result_up;
    logic [1:0]  result_down;
    logic [15:0] combo_bcd;
    logic [15:0] max_combo_bcd;
    logic [15:0] perfect_bcd;
    logic [15:0] good_bcd;
    logic [15:0] miss_bcd;
    logic        full_combo;
    logic        combo_break;

    int n_tests = 0;
    int n_fail  = 0;

    combo_tracker dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .judge_valid   (judge_valid),
        .result_up     (result_up),
        .result_down   (result_down),
        .combo_bcd     (combo_bcd),
        .max_combo_bcd (max_combo_bcd),
        .perfect_bcd   (perfect_bcd),
        .good_bcd      (good_bcd),
        .miss_bcd      (miss_bcd),
        .full_combo    (full_combo),
        .combo_break   (combo_break)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [81:0] dut_vec = {combo_bcd, max_combo_bcd, perfect_bcd, good_bcd,
                           miss_bcd, full_combo, combo_break};

    // ------------------------------------------------------------ model
    int m_combo, m_max, m_perf, m_good, m_miss;
    bit m_full, m_brk;
    // Event accepted on the previous edge, due to land on the next one.
    bit         p_v;
    logic [1:0] p_u, p_d;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [81:0] model_vec();
        return {to_bcd(m_combo), to_bcd(m_max), to_bcd(m_perf), to_bcd(m_good),
                to_bcd(m_miss), m_full, m_brk};
    endfunction

    task automatic model_reset();
        m_combo = 0; m_max = 0; m_perf = 0; m_good = 0; m_miss = 0;
        m_full = 1'b1; m_brk = 1'b0;
        p_v = 1'b0; p_u = N; p_d = N;
    endtask

    task automatic model_apply(input bit v, input logic [1:0] u, input logic [1:0] d);
        int np, ng, nm;
        m_brk = 1'b0;
        if (!v) return;
        np = int'(u == P) + int'(d == P);
        ng = int'(u == G) + int'(d == G);
        nm = int'(u == M) + int'(d == M);
        if (nm > 0) begin
            m_brk   = (m_combo != 0);
            m_combo = 0;
            m_full  = 1'b0;
        end else begin
            m_combo = sat(m_combo + np + ng);
        end
        if (m_combo > m_max) m_max = m_combo;
        m_perf = sat(m_perf + np);
        m_good = sat(m_good + ng);
        m_miss = sat(m_miss + nm);
    endtask

    // One clock: drive at negedge, let the edge happen, return at next negedge.
    task automatic cycle(input bit c, input bit v, input logic [1:0] u, input logic [1:0] d);
        clr = c; judge_valid = v; result_up = u; result_down = d;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            model_apply(p_v, p_u, p_d);
            p_v = v; p_u = u; p_d = d;
        end
        @(negedge clk);
        clr = 1'b0; judge_valid = 1'b0; result_up = N; result_down = N;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        repeat (3) cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if (dut_vec !== {80'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", dut_vec, {80'h0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_basic_combo();
        cycle(1'b0, 1'b1, P, G);
        n_tests++;
        if (combo_bcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL latency_one_clock: combo=%h required 0000", combo_bcd);
        end
        cycle(1'b0, 1'b1, P, G);
        n_tests++;
        if (combo_bcd !== 16'h0002) begin
            n_fail++;
            $display("FAIL latency_two_clocks: combo=%h required 0002", combo_bcd);
        end
        repeat (10) cycle(1'b0, 1'b1, P, G);
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if (dut_vec !== {16'h0024, 16'h0024, 16'h0012, 16'h0012, 16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL twelve_events: got %h required combo=0024 max=0024 perf=0012 good=0012 miss=0000 fc=1", dut_vec);
        end
        n_tests++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL twelve_events_model: got %h required %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_miss_break();
        cycle(1'b0, 1'b1, P, M);
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if (dut_vec !== {16'h0000, 16'h0024, 16'h0013, 16'h0012, 16'h0001, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL miss_event: got %h required combo=0000 max=0024 perf=0013 good=0012 miss=0001 fc=0 brk=1", dut_vec);
        end
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if (combo_break !== 1'b0) begin
            n_fail++;
            $display("FAIL break_one_cycle: combo_break=%b required 0", combo_break);
        end
        cycle(1'b0, 1'b1, M, N);
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if ({combo_break, miss_bcd, full_combo} !== {1'b0, 16'h0002, 1'b0}) begin
            n_fail++;
            $display("FAIL miss_at_zero: brk=%b miss=%h fc=%b required brk=0 miss=0002 fc=0",
                     combo_break, miss_bcd, full_combo);
        end
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b0, N, N);
        for (int i = 0; i < 4998; i++) cycle(1'b0, 1'b1, P, P);
        cycle(1'b0, 1'b1, P, N);
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if (combo_bcd !== 16'h9997) begin
            n_fail++;
            $display("FAIL preload_9997: combo=%h required 9997", combo_bcd);
        end
        cycle(1'b0, 1'b1, P, P);
        cycle(1'b0, 1'b1, P, P);
        n_tests++;
        if (combo_bcd !== 16'h9999) begin
            n_fail++;
            $display("FAIL sat_first: combo=%h required 9999", combo_bcd);
        end
        cycle(1'b0, 1'b1, P, P);
        n_tests++;
        if (combo_bcd !== 16'h9999) begin
            n_fail++;
            $display("FAIL sat_second: combo=%h required 9999", combo_bcd);
        end
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if ({combo_bcd, max_combo_bcd, perfect_bcd} !== {16'h9999, 16'h9999, 16'h9999}) begin
            n_fail++;
            $display("FAIL sat_third: combo=%h max=%h perf=%h required 9999 9999 9999",
                     combo_bcd, max_combo_bcd, perfect_bcd);
        end
    endtask

    task automatic test_bcd_carry();
        cycle(1'b1, 1'b0, N, N);
        for (int i = 0; i < 499; i++) cycle(1'b0, 1'b1, P, P);
        cycle(1'b0, 1'b1, G, G);
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if ({combo_bcd, good_bcd} !== {16'h1000, 16'h0002}) begin
            n_fail++;
            $display("FAIL carry_0998: combo=%h good=%h required 1000 0002", combo_bcd, good_bcd);
        end
        cycle(1'b1, 1'b0, N, N);
        for (int i = 0; i < 499; i++) cycle(1'b0, 1'b1, P, P);
        cycle(1'b0, 1'b1, N, P);
        cycle(1'b0, 1'b1, P, P);
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if ({combo_bcd, perfect_bcd} !== {16'h1001, 16'h1001}) begin
            n_fail++;
            $display("FAIL carry_0999: combo=%h perf=%h required 1001 1001", combo_bcd, perfect_bcd);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 1'b0, N, N);
        repeat (3) cycle(1'b0, 1'b1, G, N);
        repeat (2) cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if ({good_bcd, combo_bcd, perfect_bcd} !== {16'h0003, 16'h0003, 16'h0000}) begin
            n_fail++;
            $display("FAIL back_to_back: good=%h combo=%h perf=%h required 0003 0003 0000",
                     good_bcd, combo_bcd, perfect_bcd);
        end
    endtask

    task automatic test_clr();
        repeat (3) cycle(1'b0, 1'b1, P, G);
        cycle(1'b0, 1'b1, P, M);
        // Stage 1 now holds an event; clr collides with a fresh judge_valid.
        cycle(1'b1, 1'b1, P, P);
        n_tests++;
        if (dut_vec !== {80'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_collision: got %h required all-zero fc=1", dut_vec);
        end
        repeat (2) cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if (dut_vec !== {80'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_discard: got %h required all-zero fc=1", dut_vec);
        end
    endtask

    task automatic test_async_rst();
        repeat (4) cycle(1'b0, 1'b1, G, P);
        cycle(1'b0, 1'b1, M, G);
        cycle(1'b0, 1'b0, N, N);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dut_vec !== {80'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst: got %h required all-zero fc=1 before clock edge", dut_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, N, N);
        n_tests++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL after_rst: got %h required %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        bit         c, v;
        logic [1:0] u, d;
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 39) == 0);
            v = $urandom_range(0, 1) != 0;
            u = 2'($urandom_range(0, 3));
            d = 2'($urandom_range(0, 3));
            // Keep misses rarer so combos grow long enough to matter.
            if (u == M && $urandom_range(0, 2) != 0) u = P;
            if (d == M && $urandom_range(0, 2) != 0) d = G;
            cycle(c, v, u, d);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h required %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; judge_valid = 1'b0; result_up = N; result_down = N;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic_combo();
        test_miss_break();
        test_saturation();
        test_bcd_carry();
        test_back_to_back();
        test_clr();
        test_async_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
